// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;
  localparam int DEF_NWR   = 2;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, write clears, flush wipes, plus a
// registered popcount of the next-state busy vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int AW       = clog2(NREGS),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_en_i,
  input  logic [AW-1:0]    iss_addr_i,
  input  logic             flush_i,
  input  logic [NREGS-1:0] wr_match_i,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      busy_cnt_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] iss_dec;
  logic [AW:0]      cnt_nxt;

  always_comb begin
    iss_dec = '0;
    for (int r = 0; r < NREGS; r++)
      iss_dec[r] = iss_en_i && (iss_addr_i == AW'(r)) && !(ZERO_REG && r == 0);
  end

  // Issue outranks a same-cycle write clear; flush keeps only the new issue.
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush_i)            busy_nxt[r] = iss_dec[r];
      else if (iss_dec[r])    busy_nxt[r] = 1'b1;
      else if (wr_match_i[r]) busy_nxt[r] = 1'b0;
    end
    if (!rst) busy_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk) begin
    busy_q     <= busy_nxt;
    busy_cnt_o <= cnt_nxt;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a busy scoreboard
// for RAW-hazard stalls at decode.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN     = DEF_XLEN,
  parameter int  NREGS    = DEF_NREGS,
  parameter int  NRD      = DEF_NRD,
  parameter int  NWR      = DEF_NWR,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i,
  output logic [AW:0]         busy_cnt_o
);

  logic [NREGS-1:0][XLEN-1:0] mem_q;
  logic [NREGS-1:0][XLEN-1:0] win_data;
  logic [NREGS-1:0]           win_en;
  logic [NREGS-1:0]           busy;
  logic [AW-1:0]              wa;

  // Ascending port scan: a later (higher) port overrides an earlier one.
  always_comb begin
    win_en   = '0;
    win_data = '0;
    wa       = '0;
    for (int p = 0; p < NWR; p++) begin
      wa = wr_addr_i[p*AW +: AW];
      if (wr_en_i[p] && !(ZERO_REG && wa == '0)) begin
        win_en[wa]   = 1'b1;
        win_data[wa] = wr_data_i[p*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        if (win_en[r]) mem_q[r] <= win_data[r];
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .flush_i    (flush_i),
    .wr_match_i (win_en),
    .busy_o     (busy),
    .busy_cnt_o (busy_cnt_o)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zr;
    assign ra = rd_addr_i[k*AW +: AW];
    assign zr = ZERO_REG && (ra == '0);

    // A pending write to the read address resolves the hazard this cycle.
    assign rd_data_o[k*XLEN +: XLEN] = (!rst || zr) ? '0 :
                                       win_en[ra]    ? win_data[ra] : mem_q[ra];
    assign rd_busy_o[k] = rst && !zr && busy[ra] && !win_en[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized check of regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                iss_en = 1'b0;
  logic [AW-1:0]       iss_addr = '0;
  logic                flush = 1'b0;
  logic [AW:0]         busy_cnt;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .flush_i    (flush),
    .busy_cnt_o (busy_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy[NREGS];
  int              m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int wa(int p); return int'(wr_addr[p*AW +: AW]); endfunction
  function automatic int ra(int k); return int'(rd_addr[k*AW +: AW]); endfunction

  // Highest write port targeting a, or -1.
  function automatic int winner(int a);
    for (int p = NWR-1; p >= 0; p--)
      if (wr_en[p] && wa(p) == a) return p;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(int a);
    int p;
    if (!rst || a == 0) return '0;
    p = winner(a);
    if (p >= 0) return wr_data[p*XLEN +: XLEN];
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(int a);
    if (!rst || a == 0) return 1'b0;
    if (winner(a) >= 0) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wa(p) != 0) begin
          m_mem[wa(p)]  = wr_data[p*XLEN +: XLEN];
          m_busy[wa(p)] = 0;
        end
      if (flush)
        for (int r = 0; r < NREGS; r++) m_busy[r] = 0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
    m_cnt = 0;
    for (int r = 0; r < NREGS; r++) m_cnt += m_busy[r];
  endtask

  // Check comb outputs, take the edge, update model, check the count.
  task automatic cycle();
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rd_data%0d", k), 64'(rd_data[k*XLEN +: XLEN]), 64'(exp_rd(ra(k))));
      chk($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(exp_busy(ra(k))));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("busy_cnt", 64'(busy_cnt), 64'(m_cnt));
  endtask

  task automatic idle();
    wr_en = '0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rdp(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic iss(input int a);
    iss_en = 1'b1; iss_addr = AW'(a);
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin m_mem[r] = '0; m_busy[r] = 0; end

    // Reset with writes and an issue pending
    rst = 1'b0;
    wr(0, 5, 32'h1234_5678); wr(1, 6, 32'hCAFE_F00D); iss(5);
    rdp(0, 5); rdp(1, 6);
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("rst_rd0", 64'(rd_data[31:0]), 64'h0);
      chk("rst_busy", 64'(rd_busy), 64'h0);
      cycle();
    end
    chk("rst_cnt", 64'(busy_cnt), 64'h0);
    rst = 1'b1; idle(); rdp(0, 5);
    #2; chk("post_rst_r5", 64'(rd_data[31:0]), 64'h0); cycle();

    // Bypass
    idle(); wr(0, 3, 32'hDEAD_BEEF); rdp(0, 3);
    #2; chk("byp_same", 64'(rd_data[31:0]), 64'hDEAD_BEEF); cycle();
    idle();
    #2; chk("byp_next", 64'(rd_data[31:0]), 64'hDEAD_BEEF); cycle();

    // Write collision: higher port wins
    idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rdp(0, 7); rdp(1, 7);
    #2; chk("coll_same", 64'(rd_data[63:32]), 64'h22); cycle();
    idle();
    #2; chk("coll_next", 64'(rd_data[31:0]), 64'h22); cycle();

    // Zero register
    idle(); wr(0, 0, 32'hFFFF_FFFF); iss(0); rdp(0, 0);
    #2; chk("r0_same", 64'(rd_data[31:0]), 64'h0); cycle();
    idle();
    #2;
    chk("r0_next", 64'(rd_data[31:0]), 64'h0);
    chk("r0_busy", 64'(rd_busy[0]), 64'h0);
    chk("r0_cnt", 64'(busy_cnt), 64'h0);
    cycle();

    // Scoreboard
    idle(); iss(4); rdp(0, 4); #2; cycle();
    idle(); #2;
    chk("sb_iss_busy", 64'(rd_busy[0]), 64'h1);
    chk("sb_iss_cnt", 64'(busy_cnt), 64'h1);
    cycle();
    idle(); wr(1, 4, 32'h44); #2;
    chk("sb_wr_busy", 64'(rd_busy[0]), 64'h0);
    cycle();
    chk("sb_wr_cnt", 64'(busy_cnt), 64'h0);
    idle(); iss(4); wr(0, 4, 32'h45); #2; cycle();
    idle(); #2;
    chk("sb_iss_wr_busy", 64'(rd_busy[0]), 64'h1);
    cycle();
    idle(); wr(0, 4, 32'h46); #2; cycle();

    // Flush
    for (int a = 1; a <= 3; a++) begin idle(); iss(a); #2; cycle(); end
    chk("fl_cnt3", 64'(busy_cnt), 64'h3);
    idle(); flush = 1'b1; iss(9); #2; cycle();
    chk("fl_cnt1", 64'(busy_cnt), 64'h1);
    idle(); rdp(0, 9); rdp(1, 1); #2;
    chk("fl_r9", 64'(rd_busy[0]), 64'h1);
    chk("fl_r1", 64'(rd_busy[1]), 64'h0);
    cycle();

    // Randomized traffic, addresses biased low to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 31) == 0);
      for (int p = 0; p < NWR; p++)
        if ($urandom_range(0, 1) == 1)
          wr(p, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1), $urandom);
      for (int k = 0; k < NRD; k++)
        rdp(k, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
      if ($urandom_range(0, 1) == 1)
        iss($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
      #2;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
